// File: rtl/mem64_responder_if.sv
// CPU-side request/response and memory-side port bundle for mem64_responder.
// The master modport is the environment (CPU plus memory), the slave modport is the responder.
interface mem64_responder_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_wr;
    logic [31:0] m_rdata;

    modport master (
        output req, we, addr, wdata, size, uns, m_rdata,
        input  rdata, ack, err, busy, m_addr, m_wdata, m_wr
    );

    modport slave (
        input  req, we, addr, wdata, size, uns, m_rdata,
        output rdata, ack, err, busy, m_addr, m_wdata, m_wr
    );
endinterface

// File: rtl/mem64_responder.sv
// Bridges 8/16/32/64-bit CPU loads and stores onto a synchronous 32-bit memory,
// using two word accesses for doubles and read-modify-write for byte/half stores.
module mem64_responder (
    input logic              clk,
    input logic              rst_n,
    mem64_responder_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StCapA,
        StRdB,
        StCapB,
        StWrA,
        StWrB,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Latched request fields
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;

    // Registered outputs and the low word of a double load
    logic [31:0] lo_q, lo_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        m_wr_q, m_wr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_we;
    logic        cur_uns;
    logic        misaligned;
    logic [31:0] base_addr;
    logic [31:0] shifted;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [63:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[63:32];

    // In idle the request is decided from the live inputs; later states use the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            cur_addr  = bus.addr[31:0];
            cur_wdata = bus.wdata;
            cur_size  = bus.size;
            cur_we    = bus.we;
            cur_uns   = bus.uns;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_we    = we_q;
            cur_uns   = uns_q;
        end
    end

    always_comb begin
        unique case (cur_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = cur_addr[0];
            2'd2:    misaligned = |cur_addr[1:0];
            default: misaligned = |cur_addr[2:0];
        endcase
    end

    assign base_addr = {cur_addr[31:2], 2'b00};

    // Load lane selection and extension from the word currently on m_rdata
    always_comb begin
        shifted   = bus.m_rdata >> {cur_addr[1:0], 3'b000};
        lane_byte = shifted[7:0];
        lane_half = cur_addr[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
        unique case (cur_size)
            2'd0: load_ext = cur_uns ? {56'd0, lane_byte} : {{56{lane_byte[7]}}, lane_byte};
            2'd1: load_ext = cur_uns ? {48'd0, lane_half} : {{48{lane_half[15]}}, lane_half};
            2'd2: load_ext = cur_uns ? {32'd0, bus.m_rdata}
                                     : {{32{bus.m_rdata[31]}}, bus.m_rdata};
            default: load_ext = {bus.m_rdata, lo_q};
        endcase
    end

    // Byte/half store merge into the captured word
    always_comb begin
        if (cur_size == 2'd0) begin
            lane_mask = 32'h0000_00ff << {cur_addr[1:0], 3'b000};
            lane_ins  = {24'd0, cur_wdata[7:0]} << {cur_addr[1:0], 3'b000};
        end else begin
            lane_mask = cur_addr[1] ? 32'hffff_0000 : 32'h0000_ffff;
            lane_ins  = cur_addr[1] ? {cur_wdata[15:0], 16'd0} : {16'd0, cur_wdata[15:0]};
        end
        merged = (bus.m_rdata & ~lane_mask) | lane_ins;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (misaligned) begin
                        state_d = StResp;
                    end else if (cur_we && cur_size[1]) begin
                        state_d = StWrA;
                    end else begin
                        state_d = StRdA;
                    end
                end
            end
            StRdA:  state_d = StCapA;
            StCapA: begin
                if (cur_we) begin
                    state_d = StWrA;
                end else if (cur_size == 2'd3) begin
                    state_d = StRdB;
                end else begin
                    state_d = StResp;
                end
            end
            StRdB:  state_d = StCapB;
            StCapB: state_d = StResp;
            StWrA:  state_d = (cur_size == 2'd3) ? StWrB : StResp;
            StWrB:  state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the state being entered
    always_comb begin
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wr_d    = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        lo_d      = lo_q;
        unique case (state_d)
            StRdA: m_addr_d = base_addr;
            StRdB: m_addr_d = base_addr + 32'd4;
            StWrA: begin
                m_addr_d  = base_addr;
                m_wdata_d = cur_size[1] ? cur_wdata[31:0] : merged;
                m_wr_d    = 1'b1;
            end
            StWrB: begin
                m_addr_d  = base_addr + 32'd4;
                m_wdata_d = cur_wdata[63:32];
                m_wr_d    = 1'b1;
            end
            StResp: begin
                // Only the capture states complete a load; every other path reports zero.
                err_d   = (state_q == StIdle);
                rdata_d = (state_q == StCapA || state_q == StCapB) ? load_ext : 64'd0;
            end
            default: ;
        endcase
        if (state_q == StCapA) begin
            lo_d = bus.m_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 32'd0;
            wdata_q   <= 64'd0;
            size_q    <= 2'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            lo_q      <= 32'd0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            m_wr_q    <= 1'b0;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && bus.req) begin
                addr_q  <= bus.addr[31:0];
                wdata_q <= bus.wdata;
                size_q  <= bus.size;
                we_q    <= bus.we;
                uns_q   <= bus.uns;
            end
            lo_q      <= lo_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wr_q    <= m_wr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wr    = m_wr_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
    assign bus.ack     = (state_q == StResp);
    assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem64_responder.sv
// Randomized and directed bench for mem64_responder against a byte-addressed reference memory.
module tb_mem64_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem64_responder_if bus ();

    mem64_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Environment memory: 64 words, aliased on m_addr[7:2]
    logic [31:0] env_mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];

    always @(posedge clk) begin
        if (pl_en) begin
            env_mem[pl_idx] <= pl_data;
        end else if (bus.m_wr === 1'b1) begin
            env_mem[bus.m_addr[7:2]] <= bus.m_wdata;
            wr_addr_log.push_back(bus.m_addr);
            wr_data_log.push_back(bus.m_wdata);
        end
        bus.m_rdata <= env_mem[bus.m_addr[7:2]];
    end

    // Reference model: plain little-endian byte array, address taken mod 256
    logic [7:0] ref_mem [0:255];

    function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
        int n;
        logic [63:0] v;
        logic [7:0] ba;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            ba = a[7:0] + 8'(i);
            v[8*i +: 8] = ref_mem[ba];
        end
        if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] wd);
        logic [7:0] ba;
        for (int i = 0; i < (1 << sz); i++) begin
            ba = a[7:0] + 8'(i);
            ref_mem[ba] = wd[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
                ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = 6'(idx);
        pl_data = d;
        for (int i = 0; i < 4; i++) ref_mem[8'(idx * 4 + i)] = d[8*i +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // One complete access with every observable checked against the reference model
    task automatic do_access(input string name, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [63:0] wd);
        logic mis;
        int exp_lat, exp_nwr, lat;
        logic [63:0] exp_rd;
        logic [31:0] wa, maddr_before;
        bit seen, busy_ok;
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
              (sz == 2'd3 && a[2:0] != 3'd0);
        wa = {a[31:2], 2'b00};
        exp_rd = 64'd0;
        exp_nwr = 0;
        if (mis) begin
            exp_lat = 1;
        end else if (!w) begin
            exp_rd = ref_load(a, sz, u);
            exp_lat = (sz == 2'd3) ? 5 : 3;
        end else begin
            ref_store(a, sz, wd);
            exp_nwr = (sz == 2'd3) ? 2 : 1;
            exp_lat = (sz == 2'd3) ? 3 : (sz == 2'd2) ? 2 : 4;
        end

        @(negedge clk);
        n_cmp++;
        if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle-before: ack=%b busy=%b want 0 0", name, bus.ack, bus.busy);
        end
        maddr_before = bus.m_addr;
        wr_addr_log.delete();
        wr_data_log.delete();
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u;
        bus.addr = {$urandom(), a}; bus.wdata = wd;
        lat = 0; seen = 0; busy_ok = 1;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Scramble inputs so any use of unlatched fields shows up
                bus.req = 1'b0; bus.we = 1'($urandom()); bus.size = 2'($urandom());
                bus.uns = 1'($urandom()); bus.addr = {$urandom(), $urandom()};
                bus.wdata = {$urandom(), $urandom()};
            end
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.ack === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s ack-latency: got %0d (seen=%0b) want %0d", name, lat, seen, exp_lat);
        end
        n_cmp++;
        if (bus.err !== mis) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", name, bus.err, mis);
        end
        n_cmp++;
        if (bus.rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", name, bus.rdata, exp_rd);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy: got low during access want high", name);
        end
        n_cmp++;
        if (wr_addr_log.size() != exp_nwr) begin
            n_fail++;
            $display("FAIL %s write-count: got %0d want %0d", name, wr_addr_log.size(), exp_nwr);
        end else begin
            for (int k = 0; k < exp_nwr; k++) begin
                n_cmp++;
                if (wr_addr_log[k] !== wa + 32'(4 * k) ||
                    wr_data_log[k] !== ref_word(wa + 32'(4 * k))) begin
                    n_fail++;
                    $display("FAIL %s write%0d: got %h@%h want %h@%h", name, k, wr_data_log[k],
                             wr_addr_log[k], ref_word(wa + 32'(4 * k)), wa + 32'(4 * k));
                end
            end
        end
        if (mis) begin
            n_cmp++;
            if (bus.m_addr !== maddr_before) begin
                n_fail++;
                $display("FAIL %s m_addr-held: got %h want %h", name, bus.m_addr, maddr_before);
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [63:0] exp_rd;
        rst_n = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
        bus.addr = 64'd0; bus.wdata = 64'd0;
        for (int i = 0; i < 64; i++) preload(i, $urandom());
        #1;
        n_cmp++;
        if ({bus.ack, bus.err, bus.busy, bus.m_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset-flags: got ack/err/busy/m_wr=%b want 0000",
                     {bus.ack, bus.err, bus.busy, bus.m_wr});
        end
        n_cmp++;
        if (bus.rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL reset-rdata: got %h want 0", bus.rdata);
        end
        n_cmp++;
        if (bus.m_addr !== 32'd0 || bus.m_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset-mbus: got %h/%h want 0/0", bus.m_addr, bus.m_wdata);
        end
        // A request present as reset releases is taken on the first edge
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.uns = 1'b1; bus.addr = 64'h20;
        exp_rd = ref_load(32'h20, 2'd2, 1'b1);
        @(negedge clk);
        bus.req = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first-edge-req: busy got %b want 1", bus.busy);
        end
        lat = 1;
        while (bus.ack !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 3 || bus.rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL first-edge-load: got lat %0d rdata %h want 3 %h", lat, bus.rdata, exp_rd);
        end
    endtask

    task automatic test_directed();
        preload(4, 32'h8899aabb);
        preload(5, 32'h11223344);
        do_access("ld", 1'b0, 2'd3, 1'b0, 32'h10, 64'd0);
        n_cmp++;
        if (bus.rdata !== 64'h1122_3344_8899_aabb) begin
            n_fail++;
            $display("FAIL ld-const: got %h want 112233448899aabb", bus.rdata);
        end
        do_access("lb", 1'b0, 2'd0, 1'b0, 32'h13, 64'd0);
        n_cmp++;
        if (bus.rdata !== 64'hffff_ffff_ffff_ff88) begin
            n_fail++;
            $display("FAIL lb-const: got %h want ffffffffffffff88", bus.rdata);
        end
        do_access("lbu", 1'b0, 2'd0, 1'b1, 32'h13, 64'd0);
        n_cmp++;
        if (bus.rdata !== 64'h0000_0000_0000_0088) begin
            n_fail++;
            $display("FAIL lbu-const: got %h want 0000000000000088", bus.rdata);
        end
        do_access("lh", 1'b0, 2'd1, 1'b0, 32'h12, 64'd0);
        n_cmp++;
        if (bus.rdata !== 64'hffff_ffff_ffff_8899) begin
            n_fail++;
            $display("FAIL lh-const: got %h want ffffffffffff8899", bus.rdata);
        end
        do_access("sb", 1'b1, 2'd0, 1'b0, 32'h11, 64'h5a);
        n_cmp++;
        if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'h8899_5abb) begin
            n_fail++;
            $display("FAIL sb-const: got %0d writes want 1 write of 88995abb", wr_data_log.size());
        end
        do_access("sd-top", 1'b1, 2'd3, 1'b0, 32'hffff_fff8, 64'h0102_0304_0506_0708);
        n_cmp++;
        if (wr_data_log.size() != 2 || wr_addr_log[0] !== 32'hffff_fff8 ||
            wr_data_log[0] !== 32'h0506_0708 || wr_addr_log[1] !== 32'hffff_fffc ||
            wr_data_log[1] !== 32'h0102_0304) begin
            n_fail++;
            $display("FAIL sd-top-const: got %0d writes want 05060708@fffffff8,01020304@fffffffc",
                     wr_data_log.size());
        end
        do_access("ld-mis", 1'b0, 2'd3, 1'b0, 32'hffff_fffc, 64'd0);
        do_access("lw-mis", 1'b0, 2'd2, 1'b0, 32'h02, 64'd0);
        do_access("sh-mis", 1'b1, 2'd1, 1'b0, 32'h31, 64'hbeef);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0] sz;
        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom());
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_access("rand", 1'($urandom()), sz, 1'($urandom()), a,
                      {$urandom(), $urandom()});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [63:0] exp_rd;
        int gap;
        @(negedge clk);
        a = $urandom_range(0, 63) * 4;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.uns = 1'($urandom()); bus.addr = 64'(a);
        exp_rd = ref_load(a, 2'd2, bus.uns);
        for (int k = 0; k < 6; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (bus.ack !== 1'b1 && gap < 12);
            n_cmp++;
            if (gap != ((k == 0) ? 3 : 4) || bus.rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL b2b%0d: got gap %0d rdata %h want %0d %h", k, gap, bus.rdata,
                         (k == 0) ? 3 : 4, exp_rd);
            end
            a = $urandom_range(0, 63) * 4;
            bus.addr = 64'(a); bus.uns = 1'($urandom());
            exp_rd = ref_load(a, 2'd2, bus.uns);
            if (k == 5) bus.req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [63:0] wd;
        logic [31:0] old_hi, old_rmw;
        bit ack_seen;
        wd = {$urandom(), $urandom()};
        old_hi = ref_word(32'h44);
        @(negedge clk);
        wr_addr_log.delete();
        wr_data_log.delete();
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd3; bus.addr = 64'h40; bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.m_wr !== 1'b1 || bus.m_addr !== 32'h44) begin
            n_fail++;
            $display("FAIL sd-wrb: got m_wr %b m_addr %h want 1 00000044", bus.m_wr, bus.m_addr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.m_wr, bus.ack, bus.busy} !== 3'b000 || bus.m_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL sd-abort: got m_wr/ack/busy %b m_addr %h want 000 0",
                     {bus.m_wr, bus.ack, bus.busy}, bus.m_addr);
        end
        ref_store(32'h40, 2'd2, wd);
        @(negedge clk);
        rst_n = 1'b1;
        // Byte store abandoned during its read phase
        old_rmw = ref_word(32'h50);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.addr = 64'h52; bus.wdata = 64'ha5;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) ack_seen = 1;
        end
        n_cmp++;
        if (ack_seen || wr_addr_log.size() != 1) begin
            n_fail++;
            $display("FAIL abort-writes: got ack %0b writes %0d want 0 1", ack_seen,
                     wr_addr_log.size());
        end
        n_cmp++;
        if (env_mem[16] !== wd[31:0] || env_mem[17] !== old_hi || env_mem[20] !== old_rmw) begin
            n_fail++;
            $display("FAIL abort-mem: got %h %h %h want %h %h %h", env_mem[16], env_mem[17],
                     env_mem[20], wd[31:0], old_hi, old_rmw);
        end
    endtask

    task automatic test_mem_compare();
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (env_mem[i] !== ref_word(32'(i * 4))) begin
                n_fail++;
                $display("FAIL mem[%0d]: got %h want %h", i, env_mem[i], ref_word(32'(i * 4)));
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        do_access("post-reset", 1'b0, 2'd3, 1'b1, 32'h40, 64'd0);
        test_mem_compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
